// File: rtl/data_memory_if.sv
// Core-side load/store bus of the data memory.
// The core drives the address, store data and strobe. The memory returns four load lanes.
interface data_memory_if;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in  [0:3];
    logic        mem_write_en;
    logic [7:0]  mem_data_out [0:3];

    modport master (
        output mem_addr,
        output mem_data_in,
        output mem_write_en,
        input  mem_data_out
    );

    modport slave (
        input  mem_addr,
        input  mem_data_in,
        input  mem_write_en,
        output mem_data_out
    );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with 4-lane unaligned access.
// Once the core halts, the contents freeze and every byte is streamed out once.
module data_memory #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_b,
    data_memory_if.slave         bus,
    input  logic                 halted,
    output logic                 dump_valid,
    output logic [ADDR_BITS-1:0] dump_addr,
    output logic [7:0]           dump_byte,
    output logic                 dump_done
);

    localparam int SIZE = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic                 dump_valid_q, dump_valid_d;
    logic [ADDR_BITS-1:0] dump_addr_q, dump_addr_d;
    logic [7:0]           dump_byte_q, dump_byte_d;
    logic                 dump_done_q, dump_done_d;

    logic [7:0]           mem_q [SIZE];
    logic [7:0]           mem_d [SIZE];

    logic [ADDR_BITS-1:0] addr_lo;
    logic [ADDR_BITS-1:0] lane_idx [4];
    logic                 unused_addr_hi;

    // Address bits above the array size are ignored by design.
    assign addr_lo        = bus.mem_addr[ADDR_BITS-1:0];
    assign unused_addr_hi = ^bus.mem_addr[31:ADDR_BITS];

    // Lane indices wrap naturally at ADDR_BITS width, so SIZE-1 rolls over to 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_idx[i]         = addr_lo + ADDR_BITS'(i);
            bus.mem_data_out[i] = mem_q[lane_idx[i]];
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        mem_d = mem_q;
        if (state_q == IDLE && bus.mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                mem_d[lane_idx[i]] = bus.mem_data_in[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dump_valid_d = 1'b0;
        dump_addr_d  = '0;
        dump_byte_d  = '0;
        dump_done_d  = dump_done_q;
        case (state_q)
            IDLE: begin
                if (halted) begin
                    state_d = DUMP;
                    cnt_d   = '0;
                end
            end
            DUMP: begin
                dump_valid_d = 1'b1;
                dump_addr_d  = cnt_q;
                dump_byte_d  = mem_q[cnt_q];
                cnt_d        = cnt_q + ADDR_BITS'(1);
                if (cnt_q == '1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dump_done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking ones here would race other flops.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_byte_q  <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_byte_q  <= dump_byte_d;
            dump_done_q  <= dump_done_d;
        end
    end

    // NOTE: the array is cleared by reset, so it must be built from flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_byte  = dump_byte_q;
    assign dump_done  = dump_done_q;

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressed data memory that serves the core's load/store port: it accepts `mem_addr`, `mem_data_in[0:3]` and `mem_write_en` from the core and returns `mem_data_out[0:3]`. It is the responder for the core's data interface and sits beside the core in the top-level wrapper. Once the core raises `halted`, the block freezes its contents and streams every byte out on a dump port so the testbench can compare final memory state.

## Interface
- `ADDR_BITS`, default 10: log2 of memory size in bytes; size is `SIZE = 2**ADDR_BITS`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_b`  input  1  reset, asynchronous, active-low.
- `mem_addr`  input  32  byte address of lane 0 from the core.
- `mem_data_in[0:3]`  input  4x8  store data from the core; lane i is written to byte `mem_addr+i`.
- `mem_write_en`  input  1  store strobe; writes all four lanes.
- `mem_data_out[0:3]`  output  4x8  load data to the core; lane i is byte `mem_addr+i`.
- `halted`  input  1  core halt flag; starts the freeze and dump sequence.
- `dump_valid`  output  1  `dump_byte` and `dump_addr` are valid this cycle.
- `dump_addr`  output  ADDR_BITS  byte index being dumped.
- `dump_byte`  output  8  memory content at `dump_addr`.
- `dump_done`  output  1  dump complete; sticky until reset.

## Operation
- Storage is `SIZE` bytes, little-endian. Lane 0 is the lowest address.
- Address decode:
  - Lane i index = `(mem_addr[ADDR_BITS-1:0] + i) mod SIZE`.
  - `mem_addr` bits above `ADDR_BITS-1` are ignored.
  - Unaligned access is legal. It wraps from `SIZE-1` to 0.
- Reads are combinational from the array. There is no read enable.
- Writes: on a rising edge with `mem_write_en=1` and the FSM in IDLE, all four lanes are written.
- FSM states: IDLE, DUMP, DONE.
  - IDLE -> DUMP on the first edge at which `halted=1` is sampled. The dump counter loads 0.
  - DUMP: each cycle emits one byte and increments the counter. After emitting index `SIZE-1`, the FSM goes to DONE.
  - DONE is terminal until reset.
- The freeze is sticky:
  - In DUMP and DONE, `mem_write_en` is ignored.
  - If `halted` falls during the dump, the dump still continues to completion.
- Reset:
  - Asserting `rst_b=0` at any time, including mid-dump, forces IDLE and clears the counter and every memory byte to 0.
  - All outputs read 0 during reset. `mem_data_out` is 0 because the array is 0.
  - Release is synchronous to the next rising edge.

## Timing
- Load latency is 0 cycles. `mem_data_out` follows `mem_addr` in the same cycle.
- A store takes effect at the rising edge where `mem_write_en=1`.
  - In the store cycle, a read of the same address returns the old data.
  - From the next cycle on, it returns the new data. There is no write-to-read bypass.
- Dump outputs are registered:
  - If `halted` is first sampled high at edge N, the first `dump_valid=1` (`dump_addr=0`) appears after edge N+1.
  - Index k is presented after edge N+1+k.
  - `dump_valid` stays high for exactly `SIZE` consecutive cycles.
- `dump_done` rises on the cycle after the last `dump_valid` and stays high. In that cycle `dump_valid=0`.
- A store in the cycle where `halted` is first sampled high is still committed, because the FSM is in IDLE at that edge. That byte appears in the dump.
- Outside DUMP: `dump_valid=0`, `dump_addr=0`, `dump_byte=0`.

## Test plan
- Aligned round trip:
  - Store `mem_addr=0x10`, data `{0x78,0x56,0x34,0x12}`. Then load `0x10` -> lanes `{0x78,0x56,0x34,0x12}`.
  - Load `0x12` -> lanes 0..1 = `{0x34,0x12}`.
- Wrap-around and high bits, with `ADDR_BITS=10`:
  - Store at `0x3FE` with `{0xAA,0xBB,0xCC,0xDD}` -> bytes `0x3FE`=AA, `0x3FF`=BB, `0x000`=CC, `0x001`=DD.
  - Load `0x400` (high bits ignored) -> lane 0 = `0xCC`.
- Read-during-write:
  - Hold `mem_addr=0x20` with `mem_write_en=1` for one cycle; the same-cycle load returns the old value 0.
  - The next cycle returns the new value.
- Halt and dump:
  - Write `0x5A` to byte 7, then raise `halted`.
  - Expect exactly 1024 `dump_valid` cycles with addresses 0..1023 in order, byte 7 = `0x5A`, all others 0.
  - Then `dump_done=1`, held for 100 cycles.
- Freeze:
  - During DUMP, drive `mem_write_en=1` to byte 900 and drop `halted`.
  - The dump still completes; byte 900 dumps as 0.
- Reset mid-dump:
  - Assert `rst_b=0` at dump index 300 -> `dump_valid=0` and `dump_done=0` immediately, and memory reads all 0.
  - Re-halting restarts the dump from index 0.
